hex_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares one hex-to-seven-segment decoder across NUM_DIGITS common-anode digits. It presents one 4-bit nibble per scan slot, drives the active-low digit selects, and inserts dead-time gaps to prevent ghosting. It double-buffers the displayed value behind a Load/Ready handshake, so updates take effect only at a frame boundary and never tear. It sits between datapath logic producing a hex value and the shared decoder/segment pins.

---
 rtl/hex_scan_ctrl_pkg.sv | 27 ++
 rtl/hex_scan_ctrl_tick.sv | 44 ++++
 rtl/hex_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl_pkg
//   Shared definitions for the multiplexed hex display scan controller:
//   scan state encoding, nibble width, the all-deselected select pattern
//   and a counter-width helper.
// -----------------------------------------------------------------------------
package hex_scan_ctrl_pkg;

  localparam int NIB_W      = 4;
  localparam int MAX_DIGITS = 8;

  // Common-anode selects are active low, so "nothing lit" is all ones.
  // Sized for the largest supported digit count; users slice the low bits.
  localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

  // Width of a counter that must hold 0..mod-1 (at least one bit).
  function automatic int cnt_w(input int mod);
    return (mod > 1) ? $clog2(mod) : 1;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_tick.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
//   Modulo-MOD counter with synchronous clear and a terminal-count flag.
//   Used for both the per-digit slot timer and the dead-time gap timer.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     en     : advance the count this cycle
//     clr    : force the count back to zero (wins over en)
//     tc     : high while enabled and the count sits at MOD-1; the counter
//              wraps to zero on that same edge
// -----------------------------------------------------------------------------
module scan_tick_gen
  import hex_scan_ctrl_pkg::*;
#(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = cnt_w(MOD);
  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl
//   Time-multiplexed scan controller sharing one external hex-to-7-segment
//   decoder across NUM_DIGITS common-anode digits. Each digit is selected for
//   REFRESH_DIV cycles, followed by GAP_CYCLES of all-deselected dead time to
//   stop ghosting. The shown value is double-buffered: a Load/Ready handshake
//   fills a pending register, which is copied to the display register only at
//   a frame boundary (the gap that wraps back to digit 0) or while off, so a
//   frame never mixes old and new digits.
//
//   Ports
//     clock   : clock, rising edge
//     resetn  : asynchronous active-low reset
//     enable  : 1 = scanning, 0 = display off
//     lzs     : 1 = leading-zero suppression (sampled live)
//     value   : new display value, digit i = value[4i+3:4i]
//     load    : request to capture value
//     ready   : 1 = a load is accepted this cycle
//     nibble  : digit code for the shared decoder
//     blank   : 1 = decoder output must be forced dark
//     sel     : active-low one-hot digit enables
//   All outputs are registered.
// -----------------------------------------------------------------------------
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        lzs,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        load,
  output logic                        ready,
  output logic [NIB_W-1:0]            nibble,
  output logic                        blank,
  output logic [NUM_DIGITS-1:0]       sel
);

  localparam int IW = cnt_w(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_NONE = SEL_OFF[NUM_DIGITS-1:0];

  typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] digits_t;

  scan_state_e state, state_n;
  logic [IW-1:0] idx, idx_n;

  digits_t disp, disp_n, pend;
  logic    pend_vld;

  logic slot_run, gap_run;
  logic slot_tc, gap_tc;
  logic load_acc, wrap, xfer;

  logic [NUM_DIGITS-1:0] zero_hi;
  logic                  run_zero;
  logic [NUM_DIGITS-1:0] sel_n;
  logic                  supp_n;

  // ---------------------------------------------------------------------------
  // Slot and gap timers. Each is held clear outside its own state, so it
  // always starts from zero when its state is entered.
  // ---------------------------------------------------------------------------
  assign slot_run = enable && (state == ST_SCAN);
  assign gap_run  = enable && (state == ST_GAP);

  scan_tick_gen #(.MOD(REFRESH_DIV)) u_slot (
    .clk   (clock),
    .rst_n (resetn),
    .en    (slot_run),
    .clr   (!slot_run),
    .tc    (slot_tc)
  );

  scan_tick_gen #(.MOD(GAP_CYCLES)) u_gap (
    .clk   (clock),
    .rst_n (resetn),
    .en    (gap_run),
    .clr   (!gap_run),
    .tc    (gap_tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (!enable) begin
      state_n = ST_OFF;
      idx_n   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_n = ST_SCAN;
          idx_n   = '0;
        end
        ST_SCAN: begin
          if (slot_tc) state_n = ST_GAP;
        end
        ST_GAP: begin
          if (gap_tc) begin
            state_n = ST_SCAN;
            idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state_n = ST_OFF;
          idx_n   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and double buffer. Ready is the inverse of the pending flag, so
  // a load can never collide with a transfer: a transfer needs pending set,
  // which already holds ready low.
  // ---------------------------------------------------------------------------
  assign load_acc = load && ready;
  assign wrap     = gap_run && gap_tc && (idx == LAST_IDX);
  assign xfer     = pend_vld && (wrap || (state == ST_OFF));
  assign disp_n   = xfer ? pend : disp;

  // Digit i is a suppression candidate when it and every digit above it are
  // zero. Computed on the value that will be on display next cycle so the
  // first digit-0 slot after a transfer already reflects the new value.
  always_comb begin
    zero_hi  = '0;
    run_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero   = run_zero && (disp_n[i] == '0);
      zero_hi[i] = run_zero;
    end
  end

  // Digit 0 is never suppressed, so a zero value still shows one "0".
  assign supp_n = lzs && (idx_n != '0) && zero_hi[idx_n];

  always_comb begin
    sel_n        = SEL_NONE;
    sel_n[idx_n] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State, buffers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_OFF;
      idx      <= '0;
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      ready    <= 1'b1;
      nibble   <= '0;
      blank    <= 1'b1;
      sel      <= SEL_NONE;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      disp  <= disp_n;

      if (load_acc) begin
        pend     <= value;
        pend_vld <= 1'b1;
        ready    <= 1'b0;
      end else if (xfer) begin
        pend_vld <= 1'b0;
        ready    <= 1'b1;
      end

      // Outputs track the state being entered, so they line up with it.
      if (state_n == ST_SCAN) begin
        sel    <= sel_n;
        nibble <= disp_n[idx_n];
        blank  <= supp_n;
      end else begin
        // OFF and GAP: everything dark, nibble held.
        sel   <= SEL_NONE;
        blank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic        lzs;
  logic [15:0] value;
  logic        load;
  logic        ready;
  logic [3:0]  nibble;
  logic        blank;
  logic [3:0]  sel;

  int n_chk  = 0;
  int n_fail = 0;

  hex_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .GAP_CYCLES  (1)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .lzs    (lzs),
    .value  (value),
    .load   (load),
    .ready  (ready),
    .nibble (nibble),
    .blank  (blank),
    .sel    (sel)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Bounded wait for a given select pattern; an expired bound is a failure.
  task automatic wait_sel(input logic [3:0] pat, input string nm);
    int n;
    n = 0;
    while (sel !== pat && n < 60) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (sel !== pat) begin
      n_fail++;
      $display("FAIL %s: sel=%b never reached %b", nm, sel, pat);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; lzs = 1'b0; value = 16'h0; load = 1'b0;
    tick(2);
    n_chk++;
    if (sel !== 4'b1111 || blank !== 1'b1 || ready !== 1'b1 || nibble !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_vals: sel=%b blank=%b ready=%b nib=%h want 1111 1 1 0",
               sel, blank, ready, nibble);
    end
    resetn = 1'b1;
    tick();
    n_chk++;
    if (sel !== 4'b1110 || nibble !== 4'h0 || blank !== 1'b0) begin
      n_fail++;
      $display("FAIL first_scan: sel=%b nib=%h blank=%b want 1110 0 0", sel, nibble, blank);
    end
    // Digit 0 at c..c+3, gap c+4, ..., digit 3 gap c+19, digit 0 again c+20.
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3 || i == 4 || i == 19 || i == 20) begin
        n_chk++;
        if (sel !== ((i == 4 || i == 19) ? 4'b1111 : 4'b1110)) begin
          n_fail++;
          $display("FAIL frame_period[%0d]: sel=%b want %b", i, sel,
                   (i == 4 || i == 19) ? 4'b1111 : 4'b1110);
        end
      end
    end
  endtask

  task automatic test_load();
    wait_sel(4'b1101, "ld_sync");
    load = 1'b1; value = 16'h1A3F;
    tick();
    load = 1'b0;
    n_chk++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL ld_ready_drop: ready=%b want 0", ready);
    end
    wait_sel(4'b1011, "ld_d2_old");
    n_chk++;
    if (nibble !== 4'h0) begin
      n_fail++; $display("FAIL ld_no_tear: nib=%h want 0", nibble);
    end
    wait_sel(4'b0111, "ld_d3_old");
    n_chk++;
    if (ready !== 1'b0 || nibble !== 4'h0) begin
      n_fail++; $display("FAIL ld_pre_wrap: ready=%b nib=%h want 0 0", ready, nibble);
    end
    wait_sel(4'b1110, "ld_d0");
    n_chk++;
    if (nibble !== 4'hF || ready !== 1'b1) begin
      n_fail++; $display("FAIL ld_d0: nib=%h ready=%b want F 1", nibble, ready);
    end
    wait_sel(4'b1101, "ld_d1");
    n_chk++;
    if (nibble !== 4'h3) begin n_fail++; $display("FAIL ld_d1: nib=%h want 3", nibble); end
    wait_sel(4'b1011, "ld_d2");
    n_chk++;
    if (nibble !== 4'hA) begin n_fail++; $display("FAIL ld_d2: nib=%h want A", nibble); end
    wait_sel(4'b0111, "ld_d3");
    n_chk++;
    if (nibble !== 4'h1) begin n_fail++; $display("FAIL ld_d3: nib=%h want 1", nibble); end
  endtask

  task automatic test_back_to_back();
    wait_sel(4'b1101, "b2b_sync");
    load = 1'b1; value = 16'h1A3F;
    tick();
    value = 16'h0000;   // still loading, but ready is now low
    n_chk++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready: ready=%b want 0", ready);
    end
    tick();
    load = 1'b0;
    for (int f = 0; f < 2; f++) begin
      wait_sel(4'b1110, "b2b_d0");
      n_chk++;
      if (nibble !== 4'hF) begin
        n_fail++; $display("FAIL b2b_d0[%0d]: nib=%h want F", f, nibble);
      end
      wait_sel(4'b0111, "b2b_d3");
      n_chk++;
      if (nibble !== 4'h1 || ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_d3[%0d]: nib=%h ready=%b want 1 1", f, nibble, ready);
      end
    end
  endtask

  task automatic test_lzs();
    lzs = 1'b1;
    load = 1'b1; value = 16'h0050;
    tick();
    load = 1'b0;
    wait_sel(4'b1110, "lzs_d0");
    n_chk++;
    if (nibble !== 4'h0 || blank !== 1'b0) begin
      n_fail++; $display("FAIL lzs_d0: nib=%h blank=%b want 0 0", nibble, blank);
    end
    wait_sel(4'b1101, "lzs_d1");
    n_chk++;
    if (nibble !== 4'h5 || blank !== 1'b0) begin
      n_fail++; $display("FAIL lzs_d1: nib=%h blank=%b want 5 0", nibble, blank);
    end
    wait_sel(4'b1011, "lzs_d2");
    n_chk++;
    if (blank !== 1'b1) begin n_fail++; $display("FAIL lzs_d2: blank=%b want 1", blank); end
    wait_sel(4'b0111, "lzs_d3");
    n_chk++;
    if (blank !== 1'b1) begin n_fail++; $display("FAIL lzs_d3: blank=%b want 1", blank); end
    // All-zero value: only digit 0 remains lit.
    load = 1'b1; value = 16'h0000;
    tick();
    load = 1'b0;
    wait_sel(4'b1110, "lzs0_d0");
    n_chk++;
    if (nibble !== 4'h0 || blank !== 1'b0) begin
      n_fail++; $display("FAIL lzs0_d0: nib=%h blank=%b want 0 0", nibble, blank);
    end
    wait_sel(4'b1101, "lzs0_d1");
    n_chk++;
    if (blank !== 1'b1) begin n_fail++; $display("FAIL lzs0_d1: blank=%b want 1", blank); end
    // Lzs is live: turning it off unblanks the upper zero digits right away.
    lzs = 1'b0;
    wait_sel(4'b1011, "lzs0_d2");
    n_chk++;
    if (blank !== 1'b0 || nibble !== 4'h0) begin
      n_fail++; $display("FAIL lzs_live: blank=%b nib=%h want 0 0", blank, nibble);
    end
  endtask

  task automatic test_enable();
    wait_sel(4'b1011, "en_sync");
    tick();
    enable = 1'b0;
    tick();
    n_chk++;
    if (sel !== 4'b1111 || blank !== 1'b1) begin
      n_fail++; $display("FAIL en_off: sel=%b blank=%b want 1111 1", sel, blank);
    end
    load = 1'b1; value = 16'h00C7;
    tick();
    load = 1'b0;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL off_load: ready=%b want 0", ready); end
    tick();
    n_chk++;
    if (ready !== 1'b1 || sel !== 4'b1111) begin
      n_fail++; $display("FAIL off_xfer: ready=%b sel=%b want 1 1111", ready, sel);
    end
    enable = 1'b1;
    tick();
    n_chk++;
    if (sel !== 4'b1110 || nibble !== 4'h7) begin
      n_fail++; $display("FAIL reenable: sel=%b nib=%h want 1110 7", sel, nibble);
    end
    wait_sel(4'b1101, "reen_d1");
    n_chk++;
    if (nibble !== 4'hC) begin n_fail++; $display("FAIL reen_d1: nib=%h want C", nibble); end
  endtask

  task automatic test_reset_mid_gap();
    load = 1'b1; value = 16'hBEEF;
    tick();
    load = 1'b0;
    wait_sel(4'b1111, "rst_gap");
    resetn = 1'b0;
    #1;
    n_chk++;
    if (sel !== 4'b1111 || blank !== 1'b1 || ready !== 1'b1 || nibble !== 4'h0) begin
      n_fail++;
      $display("FAIL async_rst: sel=%b blank=%b ready=%b nib=%h want 1111 1 1 0",
               sel, blank, ready, nibble);
    end
    tick();
    resetn = 1'b1;
    tick();
    n_chk++;
    if (sel !== 4'b1110 || nibble !== 4'h0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst: sel=%b nib=%h ready=%b want 1110 0 1", sel, nibble, ready);
    end
    wait_sel(4'b1101, "post_d1");
    n_chk++;
    if (nibble !== 4'h0) begin n_fail++; $display("FAIL post_d1: nib=%h want 0", nibble); end
    wait_sel(4'b1110, "post_wrap");
    n_chk++;
    if (nibble !== 4'h0) begin n_fail++; $display("FAIL pend_lost: nib=%h want 0", nibble); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_lzs();
    test_enable();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
